cfir_pe_array: RTL and testbench
================================

Name: cfir_pe_array

Overview:
- Parametrised complex FIR engine for the overlay datapath, successor to the fixed pe_array.
- NUM_TAPS complex coefficients are loaded over the same valid/data stream used for samples, selected by the load strobe.
- In compute mode the block produces one scaled, saturated complex output per accepted sample.
- Sits between the overlay input FIFO and the output stage; single clock domain.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component (signed two's complement)
- NUM_TAPS, 8, number of complex taps (>=2)
- SHIFT, 0, arithmetic right shift applied to the accumulated sum before saturation (0..DATA_WIDTH)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  1 = coefficient load mode, 0 = compute mode
- din_v  in  1  din valid
- din  in  2*DATA_WIDTH  {re[2*DW-1:DW], im[DW-1:0]}; coefficient in load mode, sample in compute mode
- dout_v  out  1  one-cycle output valid
- dout  out  2*DATA_WIDTH  {re, im} filter output
- coef_ready  out  1  all NUM_TAPS coefficients loaded

Behaviour:
- Reset (async assert, sync release): all coefficients, delay line, write index and pipeline valids cleared; dout_v=0, dout=0, coef_ready=0.
- Load start: on the first cycle with load=1 after load=0 (registered edge detect, includes the first cycle after reset):
  - write index cleared to 0;
  - all coefficients cleared;
  - delay line zeroed;
  - coef_ready cleared;
  - pipeline valids flushed.
- Load words:
  - Each cycle with load=1 and din_v=1 writes din to coef[idx], then idx++.
  - This includes the cycle in which the load-start edge is detected: that word goes to coef[0].
  - The word that fills coef[NUM_TAPS-1] sets coef_ready=1 on the same edge.
  - Further words while load=1 are ignored; idx saturates at NUM_TAPS.
- Partial load: if load drops with idx<NUM_TAPS, coef_ready stays 0.
- Compute with coef_ready=0: samples are dropped and no dout_v is produced.
- Compute with load=0, din_v=1, coef_ready=1 (sample accepted):
  - x shifts into delay line x[0] (x[k] <= x[k-1]).
  - y = sum over k of coef[k]*x[k]; delay line zeros act as zero history.
- While load=1, the pipeline valid bits are forced to 0, so in-flight outputs are discarded.
- Complex multiply, with operands coef=a, sample=b:
  - re = ar*br - ai*bi
  - im = ar*bi + ai*br
  - full width 2*DW+1 per component.
- Accumulation: full precision, width 2*DW+1+clog2(NUM_TAPS); no intermediate truncation.
- Output scaling:
  - arithmetic shift right by SHIFT (floor);
  - saturate to [-2^(DW-1), 2^(DW-1)-1] per component, independently.
- Pipeline and latency:
  - stage1 = delay-line register;
  - stage2 = registered products;
  - stage3 = registered sum/shift/saturate to dout.
  - A sample accepted at edge t gives dout_v=1 for exactly the cycle following edge t+2, i.e. latency 3 edges.
- Throughput: back-to-back samples give back-to-back outputs, one per cycle.
- Hold behaviour: din_v gaps insert no outputs and do not shift the delay line. dout holds its last value when dout_v=0.
- Simultaneous events:
  - load=1 with din_v=1 is always a coefficient write, never a sample.
  - rst_n low overrides everything, including mid-load and mid-pipeline.

Test Plan:
- Single tap: load c0=0004_0002, c1..c7=0; send x=0003_0001 -> dout_v 3 edges later, dout=000A_000A (12-2, 4+6).
- Two-tap moving sum: c0=c1=0001_0000, others 0; send 0001_0001, 0002_0002, 0003_0003 back-to-back -> dout=0001_0001, 0003_0003, 0005_0005 on consecutive cycles.
- Saturation, SHIFT=0: c0=7FFF_0000; x=7FFF_0000 -> 7FFF_0000; x=8000_0000 -> 8000_0000.
- SHIFT=1 build: c0=0003_0000; x=0003_0000 (re=9) -> dout=0004_0000; x=FFFD_0000 (re=-9) -> dout=FFFB_0000 (floor).
- Partial load: 3 coefficient words then load=0, send 4 samples -> coef_ready=0, no dout_v.
- Reload mid-stream: assert load one cycle after a sample is accepted -> that output is never emitted. After 8 new coefficients, delay history is zero: the first output uses only x[0].
- Reset mid-load: pull rst_n low after 5 coefficients -> coef_ready=0, dout=0 immediately; a full reload is required before any output.

Source files
------------

// File: rtl/cfir_pe_array.sv
// Complex FIR engine: NUM_TAPS complex taps are loaded over the sample stream, then
// each accepted sample yields one scaled, saturated complex output three edges later.
module cfir_pe_array #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int SHIFT      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    din_v,
  input  logic [2*DATA_WIDTH-1:0] din,
  output logic                    dout_v,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    coef_ready
);
  // Handshake: din_v is a qualify-only strobe with no backpressure; dout_v is a
  // one-cycle pulse per result, and dout holds its last value between pulses.
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2*DW + 1;
  localparam int AW = PW + $clog2(NUM_TAPS);
  localparam int IW = $clog2(NUM_TAPS + 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0] c_re [NUM_TAPS];
  logic signed [DW-1:0] c_im [NUM_TAPS];
  logic signed [DW-1:0] x_re [NUM_TAPS];
  logic signed [DW-1:0] x_im [NUM_TAPS];
  logic signed [PW-1:0] m_re [NUM_TAPS];
  logic signed [PW-1:0] m_im [NUM_TAPS];
  logic signed [PW-1:0] p_re [NUM_TAPS];
  logic signed [PW-1:0] p_im [NUM_TAPS];
  logic signed [DW-1:0] din_re, din_im;
  logic signed [AW-1:0] acc_re, acc_im, sh_re, sh_im;
  logic [IW-1:0] idx, wr_idx;
  logic load_q, load_start, v1, v2;

  assign din_re     = din[2*DW-1:DW];
  assign din_im     = din[DW-1:0];
  assign load_start = load & ~load_q;
  // The word arriving on the load-start cycle lands in coef[0] regardless of idx.
  assign wr_idx     = load_start ? '0 : idx;

  function automatic logic [DW-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    else                  return v[DW-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      m_re[k] = PW'(c_re[k]) * PW'(x_re[k]) - PW'(c_im[k]) * PW'(x_im[k]);
      m_im[k] = PW'(c_re[k]) * PW'(x_im[k]) + PW'(c_im[k]) * PW'(x_re[k]);
    end
  end

  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_re = acc_re + AW'(p_re[k]);
      acc_im = acc_im + AW'(p_im[k]);
    end
    sh_re = acc_re >>> SHIFT;
    sh_im = acc_im >>> SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_re[k] <= '0;
        p_im[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        p_re[k] <= m_re[k];
        p_im[k] <= m_im[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        c_re[k] <= '0;
        c_im[k] <= '0;
        x_re[k] <= '0;
        x_im[k] <= '0;
      end
      idx        <= '0;
      load_q     <= 1'b0;
      coef_ready <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_v     <= 1'b0;
      dout       <= '0;
    end else begin
      load_q <= load;
      if (load) begin
        v1     <= 1'b0;
        v2     <= 1'b0;
        dout_v <= 1'b0;
        if (load_start) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            c_re[k] <= '0;
            c_im[k] <= '0;
            x_re[k] <= '0;
            x_im[k] <= '0;
          end
          idx        <= '0;
          coef_ready <= 1'b0;
        end
        if (din_v && (wr_idx < IW'(NUM_TAPS))) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            if (wr_idx == IW'(k)) begin
              c_re[k] <= din_re;
              c_im[k] <= din_im;
            end
          end
          idx <= wr_idx + IW'(1);
          if (wr_idx == IW'(NUM_TAPS-1)) coef_ready <= 1'b1;
        end
      end else begin
        v1 <= din_v & coef_ready;
        if (din_v && coef_ready) begin
          x_re[0] <= din_re;
          x_im[0] <= din_im;
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_re[k] <= x_re[k-1];
            x_im[k] <= x_im[k-1];
          end
        end
        v2     <= v1;
        dout_v <= v2;
        if (v2) dout <= {sat(sh_re), sat(sh_im)};
      end
    end
  end
endmodule

// File: tb/tb_cfir_pe_array.sv
// Randomised scoreboard bench for cfir_pe_array; SHIFT=0 and SHIFT=1 instances share
// stimulus and are checked against a plain-arithmetic convolution model.
module tb_cfir_pe_array;
  localparam int DW = 16;
  localparam int NT = 8;

  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, din_v = 1'b0;
  logic [31:0] din = '0;
  logic dout_v0, dout_v1, cr0, cr1;
  logic [31:0] dout0, dout1;

  cfir_pe_array #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .din_v(din_v), .din(din),
    .dout_v(dout_v0), .dout(dout0), .coef_ready(cr0));
  cfir_pe_array #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .din_v(din_v), .din(din),
    .dout_v(dout_v1), .dout(dout1), .coef_ready(cr1));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q0[$], exp_q1[$];
  int cyc_q0[$], cyc_q1[$];

  int c_re[NT], c_im[NT], h_re[NT], h_im[NT];
  int m_idx;
  bit m_ready, m_load_q;
  logic [31:0] wl[NT+2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input longint v);
    logic [63:0] t;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [31:0] model_out(input int sh);
    longint ar, ai;
    ar = 0;
    ai = 0;
    for (int k = 0; k < NT; k++) begin
      ar += longint'(c_re[k]) * h_re[k] - longint'(c_im[k]) * h_im[k];
      ai += longint'(c_re[k]) * h_im[k] + longint'(c_im[k]) * h_re[k];
    end
    return {sat16(ar >>> sh), sat16(ai >>> sh)};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) begin
      c_re[k] = 0; c_im[k] = 0; h_re[k] = 0; h_im[k] = 0;
    end
    m_idx = 0;
    m_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dout_v0) begin
      if (exp_q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dout0_unexpected got=%h exp=none (t=%0t)", dout0, $time);
      end else begin
        chk("dout0", dout0, exp_q0.pop_front());
        chk("latency0", 32'(cyc), 32'(cyc_q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (dout_v1) begin
      if (exp_q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dout1_unexpected got=%h exp=none (t=%0t)", dout1, $time);
      end else begin
        chk("dout1", dout1, exp_q1.pop_front());
        chk("latency1", 32'(cyc), 32'(cyc_q1.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; din_v = 1'b0;
    model_clear();
    m_load_q = 1'b0;
    exp_q0.delete(); exp_q1.delete(); cyc_q0.delete(); cyc_q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Leaves load high so callers can test reset mid-load; end_load drops it.
  task automatic load_words(input int n);
    load = 1'b1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        din_v = 1'b0;
        if (!m_load_q) model_clear();
        m_load_q = 1'b1;
        @(posedge clk); #1;
      end
      din = wl[i];
      din_v = 1'b1;
      if (!m_load_q) model_clear();
      m_load_q = 1'b1;
      if (m_idx < NT) begin
        c_re[m_idx] = int'($signed(wl[i][31:16]));
        c_im[m_idx] = int'($signed(wl[i][15:0]));
        m_idx++;
        if (m_idx == NT) m_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    din_v = 1'b0;
  endtask

  task automatic end_load();
    load = 1'b0; din_v = 1'b0; m_load_q = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] x, input bit expect_out);
    load = 1'b0; m_load_q = 1'b0;
    din = x; din_v = 1'b1;
    if (m_ready) begin
      for (int k = NT-1; k > 0; k--) begin
        h_re[k] = h_re[k-1]; h_im[k] = h_im[k-1];
      end
      h_re[0] = int'($signed(x[31:16]));
      h_im[0] = int'($signed(x[15:0]));
      if (expect_out) begin
        exp_q0.push_back(model_out(0)); cyc_q0.push_back(cyc + 3);
        exp_q1.push_back(model_out(1)); cyc_q1.push_back(cyc + 3);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    din_v = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    din_v = 1'b0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_q0", 32'(exp_q0.size()), 32'd0);
    chk("drain_q1", 32'(exp_q1.size()), 32'd0);
    idle(2);
  endtask

  task automatic set_coefs(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < NT+2; i++) wl[i] = '0;
    wl[0] = w0;
    wl[1] = w1;
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < NT+2; i++) wl[i] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset_coef_ready0", 32'(cr0), 32'd0);
    chk("reset_coef_ready1", 32'(cr1), 32'd0);
    chk("reset_dout0", dout0, 32'd0);
    chk("reset_dout_v0", 32'(dout_v0), 32'd0);

    // Single tap.
    set_coefs(32'h0004_0002, 32'h0);
    load_words(NT); end_load();
    chk("single_coef_ready", 32'(cr0), 32'd1);
    send(32'h0003_0001, 1'b1);
    drain();

    // Two-tap moving sum, back to back.
    set_coefs(32'h0001_0000, 32'h0001_0000);
    load_words(NT); end_load();
    send(32'h0001_0001, 1'b1);
    send(32'h0002_0002, 1'b1);
    send(32'h0003_0003, 1'b1);
    drain();

    // Saturation on both extremes.
    set_coefs(32'h7FFF_0000, 32'h0);
    load_words(NT); end_load();
    send(32'h7FFF_0000, 1'b1);
    idle(4);
    send(32'h8000_0000, 1'b1);
    drain();

    // Floor behaviour of the shift (checked on the SHIFT=1 instance).
    set_coefs(32'h0003_0000, 32'h0);
    load_words(NT); end_load();
    send(32'h0003_0000, 1'b1);
    idle(4);
    send(32'hFFFD_0000, 1'b1);
    drain();

    // Random taps (extra words beyond NT must be ignored), random samples and gaps.
    rand_coefs();
    load_words(NT+2); end_load();
    chk("rand_coef_ready", 32'(cr1), 32'd1);
    for (int i = 0; i < 30; i++) begin
      send($urandom, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Partial load: no outputs may appear.
    rand_coefs();
    load_words(3); end_load();
    chk("partial_coef_ready", 32'(cr0), 32'd0);
    for (int i = 0; i < 4; i++) send($urandom, 1'b1);
    idle(6);
    chk("partial_queue", 32'(exp_q0.size()), 32'd0);

    // Reload one cycle after an accepted sample: that output is discarded.
    rand_coefs();
    load_words(NT); end_load();
    for (int i = 0; i < 3; i++) send($urandom, 1'b1);
    drain();
    send($urandom, 1'b0);
    rand_coefs();
    load_words(NT); end_load();
    send($urandom, 1'b1);
    send($urandom, 1'b1);
    drain();

    // Reset mid-load.
    rand_coefs();
    load_words(5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_coef_ready", 32'(cr0), 32'd0);
    chk("rst_mid_dout0", dout0, 32'd0);
    chk("rst_mid_dout1", dout1, 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) send($urandom, 1'b1);
    idle(5);
    chk("post_rst_coef_ready", 32'(cr1), 32'd0);
    rand_coefs();
    load_words(NT); end_load();
    for (int i = 0; i < 6; i++) send($urandom, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
